// File: rtl/paddle_pkg.sv
// Shared paddle types and bounds, used by the input controller and by the renderer for collision limits.
package paddle_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int PADDLE_W_DEF = 64;
  localparam int PADDLE_X_MAX = SCREEN_W_DEF - PADDLE_W_DEF;
  localparam int PADDLE_X_RST = PADDLE_X_MAX / 2;
  localparam int SPEED_W      = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } dir_state_e;

  // One frame of paddle motion, saturating at both screen edges.
  function automatic logic [9:0] step_x(input logic [9:0]         x,
                                        input logic [SPEED_W-1:0] speed,
                                        input dir_state_e         st,
                                        input logic [10:0]        x_max);
    logic [10:0] x11;
    logic [10:0] sp11;
    logic [10:0] sum;
    x11    = {1'b0, x};
    sp11   = {{(11-SPEED_W){1'b0}}, speed};
    sum    = x11 + sp11;
    step_x = x;
    case (st)
      MOVE_L: step_x = (x11 < sp11) ? 10'd0 : (x - sp11[9:0]);
      MOVE_R: step_x = (sum > x_max) ? x_max[9:0] : (x + sp11[9:0]);
      default: step_x = x;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic db_o
);

  localparam int            CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any sample matching the accepted level restarts the stability window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_TC) db_d = ~db_q;
      else                 cnt_d = cnt_q + 1'b1;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Button conditioning, direction FSM and frame-locked paddle position register.
// Optional speed ramp while a direction is held: define PADDLE_ACCEL_EN.
//
// state  | meaning
// IDLE   | no button, or both buttons: paddle holds still
// MOVE_L | left only: paddle steps left each frame
// MOVE_R | right only: paddle steps right each frame
module paddle_input_ctrl
  import paddle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCREEN_W        = SCREEN_W_DEF,
  parameter int PADDLE_W        = PADDLE_W_DEF,
`ifdef PADDLE_ACCEL_EN
  parameter int MAX_STEP        = 12,
  parameter int ACCEL_FRAMES    = 8,
`endif
  parameter int PADDLE_STEP     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       vSync,
  output logic [9:0] paddle_x,
  output logic       btnL_db,
  output logic       btnR_db,
  output logic       frame_upd
);

  localparam logic [10:0]        X_MAX  = 11'(SCREEN_W - PADDLE_W);
  localparam logic [9:0]         X_RST  = 10'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [SPEED_W-1:0] STEP_V = SPEED_W'(PADDLE_STEP);

  logic       vs_meta_q, vs_sync_q, vs_prev_q, tick_q;
  logic       upd_q;
  logic [9:0] x_q, x_d;
  dir_state_e state_q, state_d;
  logic [SPEED_W-1:0] speed_use;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
    .clock(clock), .reset(reset), .btn_i(btnL), .db_o(btnL_db)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clock(clock), .reset(reset), .btn_i(btnR), .db_o(btnR_db)
  );

  // vSync idles high, so the synchroniser resets high to avoid a false tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
      upd_q     <= 1'b0;
      x_q       <= X_RST;
      state_q   <= IDLE;
    end else begin
      vs_meta_q <= vSync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      tick_q    <= vs_prev_q & ~vs_sync_q;
      upd_q     <= tick_q;
      x_q       <= x_d;
      state_q   <= state_d;
    end
  end

`ifdef PADDLE_ACCEL_EN
  localparam int               AW     = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [AW-1:0]    ACC_TC = AW'(ACCEL_FRAMES - 1);
  localparam logic [SPEED_W-1:0] MAX_V = SPEED_W'(MAX_STEP);

  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [AW-1:0]      acc_q, acc_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      speed_q <= STEP_V;
      acc_q   <= '0;
    end else begin
      speed_q <= speed_d;
      acc_q   <= acc_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    speed_use = STEP_V;
`ifdef PADDLE_ACCEL_EN
    speed_d   = speed_q;
    acc_d     = acc_q;
`endif
    if (tick_q) begin
      case ({btnL_db, btnR_db})
        2'b10:   state_d = MOVE_L;
        2'b01:   state_d = MOVE_R;
        default: state_d = IDLE;
      endcase
`ifdef PADDLE_ACCEL_EN
      // The speed for this frame already includes any increment earned on this tick.
      if (state_d == IDLE || state_d != state_q) begin
        speed_d = STEP_V;
        acc_d   = '0;
      end else if (acc_q == ACC_TC) begin
        acc_d = '0;
        if (speed_q < MAX_V) speed_d = speed_q + 1'b1;
      end else begin
        acc_d = acc_q + 1'b1;
      end
      speed_use = speed_d;
`endif
      x_d = step_x(x_q, speed_use, state_d, X_MAX);
    end
  end

  assign paddle_x  = x_q;
  assign frame_upd = upd_q;

endmodule
